// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for conv2d_stream_engine
// FSM states, output-column math and result saturation
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MAC,
    WRITE,
    ADVANCE,
    DONE
  } state_t;

  localparam int KSIZE_DEF = 3;
  localparam int IMG_W_DEF = 28;

  function automatic int kaddr_w(input int k);
    return $clog2(k * k);
  endfunction

  function automatic int out_cols(
    input int img_w,
    input int k,
    input int s
  );
    return (img_w - k) / s + 1;
  endfunction

  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] v,
    input int                 out_w
  );
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    else             return v;
  endfunction

endpackage

// File: rtl/conv2d_stream_engine_window.sv
// conv_window_sreg: KSIZE x KSIZE column shift register
// Oldest column at index 0; flat row-major read port
module conv_window_sreg
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3,
  localparam int KAW   = kaddr_w(KSIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [KSIZE*DATA_W-1:0] col_in,
  input  logic [KAW-1:0]          rd_idx,
  output logic [DATA_W-1:0]       rd_data
);

  logic [DATA_W-1:0] win_q [KSIZE*KSIZE];

  // shift left by one column, new column enters at KSIZE-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KSIZE * KSIZE; i++)
        win_q[i] <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          if (c == KSIZE - 1)
            win_q[r*KSIZE+c] <= col_in[r*DATA_W +: DATA_W];
          else
            win_q[r*KSIZE+c] <= win_q[r*KSIZE+c+1];
        end
      end
    end
  end

  assign rd_data = win_q[rd_idx];

endmodule

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming KSIZE x KSIZE convolver, one row per start
// CONV_RELU_EN clamps negative results to zero
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int COEF_W          = 8,
  parameter int KSIZE           = KSIZE_DEF,
  parameter int IMG_W           = IMG_W_DEF,
  parameter int ACC_W           = 20,
  parameter int OUT_W           = 16,
  parameter int DEST_ADDR_WIDTH = 10,
  localparam int KAW            = kaddr_w(KSIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 stride,
  input  logic [DEST_ADDR_WIDTH-1:0] in_dest_addr,
  input  logic [KSIZE*DATA_W-1:0]    col_in,
  input  logic                       col_valid,
  output logic                       col_ready,
  output logic [KAW-1:0]             kernel_addr,
  input  logic [COEF_W-1:0]          kernel_in,
  output logic [OUT_W-1:0]           out_data,
  output logic [DEST_ADDR_WIDTH-1:0] out_dest_addr,
  output logic                       dest_wr_en,
  input  logic                       dest_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int KK    = KSIZE * KSIZE;
  localparam int OC1   = out_cols(IMG_W, KSIZE, 1);
  localparam int OC2   = out_cols(IMG_W, KSIZE, 2);
  localparam int CNT_W = $clog2(KSIZE + 1);
  localparam int OCW   = $clog2(IMG_W + 1);
  localparam int MCW   = $clog2(KK + 1);

  state_t state_q, state_d;

  logic                    s2_q;
  logic [CNT_W-1:0]        col_cnt_q;
  logic [CNT_W-1:0]        adv_last;
  logic [OCW-1:0]          out_cnt_q;
  logic [MCW-1:0]          mac_cnt_q;
  logic [KAW-1:0]          pix_idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] prod;
  logic [DATA_W-1:0]       pixel;
  logic [OUT_W-1:0]        res;
  logic                    xfer;
  logic                    last;

  assign adv_last = s2_q ? CNT_W'(1) : CNT_W'(0);
  assign last = (out_cnt_q == (s2_q ? OCW'(OC2 - 1) : OCW'(OC1 - 1)));

  conv_window_sreg #(
    .DATA_W (DATA_W),
    .KSIZE  (KSIZE)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (xfer),
    .col_in   (col_in),
    .rd_idx   (pix_idx_q),
    .rd_data  (pixel)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    col_ready  = 1'b0;
    dest_wr_en = 1'b0;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    unique case (state_q)
      FILL:    col_ready = (col_cnt_q < CNT_W'(KSIZE));
      ADVANCE: col_ready = (col_cnt_q <= adv_last);
      WRITE:   dest_wr_en = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
    xfer = col_valid & col_ready;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (xfer && col_cnt_q == CNT_W'(KSIZE - 1)) state_d = MAC;
      MAC:     if (mac_cnt_q == MCW'(KK)) state_d = WRITE;
      WRITE:   if (dest_ready) state_d = last ? DONE : ADVANCE;
      ADVANCE: if (xfer && col_cnt_q == adv_last) state_d = MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // row bookkeeping: stride, column/output counters, write address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_q          <= 1'b0;
      col_cnt_q     <= '0;
      out_cnt_q     <= '0;
      out_dest_addr <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        s2_q          <= (stride == 2'd2);
        col_cnt_q     <= '0;
        out_cnt_q     <= '0;
        out_dest_addr <= in_dest_addr;
      end else if (xfer) begin
        col_cnt_q <= (state_d == MAC) ? '0 : col_cnt_q + 1'b1;
      end else if (state_q == WRITE && dest_ready) begin
        out_cnt_q     <= out_cnt_q + 1'b1;
        out_dest_addr <= out_dest_addr + 1'b1;
      end
    end
  end

  // kernel address sweep with one-cycle delayed window index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kernel_addr <= '0;
      pix_idx_q   <= '0;
      mac_cnt_q   <= '0;
    end else begin
      pix_idx_q <= kernel_addr;
      if (state_q == MAC && mac_cnt_q < MCW'(KK - 1))
        kernel_addr <= kernel_addr + 1'b1;
      else
        kernel_addr <= '0;
      if (state_q == MAC && state_d == MAC)
        mac_cnt_q <= mac_cnt_q + 1'b1;
      else
        mac_cnt_q <= '0;
    end
  end

  // pixel zero-extended times coefficient sign-extended, wraps at ACC_W
  always_comb begin
    prod = $signed({{(ACC_W-DATA_W){1'b0}}, pixel})
         * $signed({{(ACC_W-COEF_W){kernel_in[COEF_W-1]}}, kernel_in});
  end

  // accumulator cleared on MAC entry, one product per aligned cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      acc_q <= '0;
    else if (state_q != MAC && state_d == MAC)
      acc_q <= '0;
    else if (state_q == MAC && mac_cnt_q != '0)
      acc_q <= acc_q + prod;
  end

  // saturated result, optionally rectified
  always_comb begin
    res = OUT_W'(sat_signed(64'(acc_q), OUT_W));
`ifdef CONV_RELU_EN
    if (res[OUT_W-1]) res = '0;
`else
`endif
    out_data = (state_q == WRITE) ? res : '0;
  end

endmodule
